// File: rtl/store_pkg.sv
// Shared store-path definitions: FSM encoding and datapath widths common with
// the load-side zero-extend unit.
package store_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

endpackage

// File: rtl/store_byte_serializer.sv
// Narrows 16-bit register stores onto a byte-wide memory write port; word stores
// go out as two little-endian byte writes, byte stores flag lost upper bits.
module store_byte_serializer
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_data,
  input  logic              req_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              trunc_lost
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                word_q, word_d;
  logic                trunc_lost_q, trunc_lost_d;
  logic                done_q, done_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Next state, request latch, and write-port outputs derived from the next state
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    word_d       = word_q;
    trunc_lost_d = trunc_lost_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr;
          data_d       = req_data;
          word_d       = req_word;
          trunc_lost_d = !req_word && (req_data[WORD_W-1:BYTE_W] != '0);
          state_d      = WR_LO;
        end
      end
      WR_LO: begin
        if (mem_ack) begin
          if (word_q) begin
            state_d = WR_HI;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WR_HI: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte select is a 2:1 mux on the state being entered
    mem_we_d    = (state_d != IDLE);
    mem_addr_d  = (state_d == WR_HI) ? addr_d + ADDR_W'(1) : addr_d;
    mem_wdata_d = (state_d == WR_HI) ? data_d[WORD_W-1:BYTE_W] : data_d[BYTE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      word_q       <= 1'b0;
      trunc_lost_q <= 1'b0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      word_q       <= word_d;
      trunc_lost_q <= trunc_lost_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign trunc_lost = trunc_lost_q;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Scoreboard bench for store_byte_serializer: directed stores push expected
// writes and done-time trunc_lost values; a negedge monitor pops and compares.
module tb_store_byte_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        req_word;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        trunc_lost;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_wr_q[$];
  logic        exp_done_q[$];
  logic [23:0] mon_wr;
  logic        mon_tr;

  always #5 clk = ~clk;

  store_byte_serializer #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_word  (req_word),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .trunc_lost(trunc_lost)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every acknowledged write and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ack) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_wr[23:8]));
        chk("wr_data", 32'(mem_wdata), 32'(mon_wr[7:0]));
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1, none expected");
      end else begin
        mon_tr = exp_done_q.pop_front();
        chk("trunc_lost_at_done", 32'(trunc_lost), 32'(mon_tr));
      end
    end
  end

  // Issue one request in the current cycle and walk it to its done cycle.
  task automatic run_req(input logic [15:0] a, input logic [15:0] d, input logic w,
                         input int lo_wait, input int hi_wait, input logic exp_trunc,
                         input bit keep);
    logic [15:0] a1;
    a1 = a + 16'd1;
    chk("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_word  = w;
    mem_ack   = 1'b1;
    exp_wr_q.push_back({a, d[7:0]});
    if (w) exp_wr_q.push_back({a1, d[15:8]});
    exp_done_q.push_back(exp_trunc);
    tick;
    if (keep) begin
      req_addr = 16'h5555;
      req_data = 16'hAAAA;
      req_word = ~w;
    end else begin
      req_valid = 1'b0;
    end
    for (int i = 0; i <= lo_wait; i++) begin
      mem_ack = (i == lo_wait);
      chk("lo_we", 32'(mem_we), 32'd1);
      chk("lo_addr", 32'(mem_addr), 32'(a));
      chk("lo_data", 32'(mem_wdata), 32'(d[7:0]));
      chk("lo_ready", 32'(req_ready), 32'd0);
      chk("lo_done", 32'(done), 32'd0);
      tick;
    end
    if (w) begin
      for (int i = 0; i <= hi_wait; i++) begin
        mem_ack = (i == hi_wait);
        chk("hi_we", 32'(mem_we), 32'd1);
        chk("hi_addr", 32'(mem_addr), 32'(a1));
        chk("hi_data", 32'(mem_wdata), 32'(d[15:8]));
        chk("hi_ready", 32'(req_ready), 32'd0);
        chk("hi_done", 32'(done), 32'd0);
        tick;
      end
    end
    mem_ack = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_at_done", 32'(req_ready), 32'd1);
    chk("we_at_done", 32'(mem_we), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    req_data  = 16'h0;
    req_word  = 1'b0;
    mem_ack   = 1'b0;
    tick;
    tick;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trunc", 32'(trunc_lost), 32'd0);
    rst = 1'b0;
    tick;

    // Plain byte store, then a truncating one
    run_req(16'h0010, 16'h00AB, 1'b0, 0, 0, 1'b0, 1'b0);
    tick;
    chk("done_one_cycle", 32'(done), 32'd0);
    run_req(16'h0020, 16'h12F0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick;
    tick;
    chk("trunc_holds", 32'(trunc_lost), 32'd1);

    // Word store wrapping the address space clears trunc_lost
    run_req(16'hFFFF, 16'hBEEF, 1'b1, 0, 0, 1'b0, 1'b0);
    tick;

    // Two wait cycles on each byte
    run_req(16'h1234, 16'hA55A, 1'b1, 2, 2, 1'b0, 1'b0);
    tick;

    // Back-to-back chain with req_valid held high
    run_req(16'h0040, 16'h7F01, 1'b0, 0, 0, 1'b1, 1'b1);
    run_req(16'h0050, 16'h00C3, 1'b1, 0, 0, 1'b0, 1'b1);
    run_req(16'h0060, 16'h0080, 1'b0, 0, 0, 1'b0, 1'b0);
    tick;

    // Reset while the high byte is pending: low byte goes out, no done
    chk("ready_before_rst_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = 16'h0100;
    req_data  = 16'h1234;
    req_word  = 1'b1;
    mem_ack   = 1'b1;
    exp_wr_q.push_back({16'h0100, 8'h34});
    tick;
    req_valid = 1'b0;
    chk("rst_test_lo_we", 32'(mem_we), 32'd1);
    tick;
    chk("rst_test_hi_we", 32'(mem_we), 32'd1);
    chk("rst_test_hi_addr", 32'(mem_addr), 32'h0101);
    chk("rst_test_hi_data", 32'(mem_wdata), 32'h12);
    mem_ack = 1'b0;
    rst     = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    mem_ack = 1'b1;
    tick;
    chk("postrst_we", 32'(mem_we), 32'd0);
    chk("postrst_done", 32'(done), 32'd0);

    run_req(16'h0070, 16'h0099, 1'b0, 0, 0, 1'b0, 1'b0);
    tick;
    tick;
    chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    chk("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
